// File: rtl/seq_gen_pkg.sv
// Shared types and default widths for the serial pattern transmitter.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam int PAT_W_DEF = 8;
  localparam int REP_W_DEF = 4;
  localparam int GAP_W_DEF = 4;

endpackage

// File: rtl/seq_gen_shift.sv
// Loadable left shift register; the MSB is the serial output, zeros shift in.
module seq_gen_shift #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [PAT_W-1:0] load_val,
  output logic             msb
);

  logic [PAT_W-1:0] sr_q;
  logic [PAT_W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift_en) begin
      sr_d = sr_q << 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[PAT_W-1];

endmodule

// File: rtl/seq_gen_tx.sv
// Serial pattern transmitter: sends pattern[len-1:0] MSB-first, reps times,
// with gap idle cycles between repetitions.
module seq_gen_tx
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int REP_W = REP_W_DEF,
  parameter int GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             dvalid,
  output logic             sof,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  // Handshake: start is a request that is accepted on any edge where busy=0;
  // there is no back-pressure, and a request while busy=1 is dropped.
  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             dvalid_q, dvalid_d;
  logic             sof_q, sof_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sr_load, sr_shift;
  logic [PAT_W-1:0] sr_load_val;
  logic [LEN_W-1:0] len_clamped, pad_amt;
  logic [REP_W-1:0] reps_eff;
  logic [PAT_W-1:0] pat_aligned;

  // Left-align the used bits so the first bit to send sits in the MSB and
  // everything below the pattern is zero; the line then idles low by itself.
  assign len_clamped = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
  assign pad_amt     = LEN_W'(PAT_W) - len_clamped;
  assign pat_aligned = pattern << pad_amt;
  assign reps_eff    = (reps == '0) ? REP_W'(1) : reps;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      dvalid_q  <= 1'b0;
      sof_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      dvalid_q  <= dvalid_d;
      sof_q     <= sof_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    gap_d       = gap_q;
    bit_cnt_d   = bit_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_load_val = pat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d     = pat_aligned;
          len_d     = len_clamped;
          gap_d     = gap;
          rep_cnt_d = reps_eff;
          bit_cnt_d = len_clamped;
          gap_cnt_d = '0;
          if (len_clamped == '0) begin
            state_d = DONE;
          end else begin
            state_d     = SEND;
            sr_load     = 1'b1;
            sr_load_val = pat_aligned;
          end
        end
      end
      SEND: begin
        // bit_cnt_q counts the bits of this repetition still on the line,
        // including the one being presented now.
        if (bit_cnt_q > LEN_W'(1)) begin
          bit_cnt_d = bit_cnt_q - LEN_W'(1);
          sr_shift  = 1'b1;
        end else if (rep_cnt_q > REP_W'(1)) begin
          rep_cnt_d = rep_cnt_q - REP_W'(1);
          if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q;
            sr_shift  = 1'b1;
          end else begin
            sr_load   = 1'b1;
            bit_cnt_d = len_q;
          end
        end else begin
          state_d   = DONE;
          sr_shift  = 1'b1;
          bit_cnt_d = '0;
          rep_cnt_d = '0;
        end
      end
      GAP: begin
        if (gap_cnt_q > GAP_W'(1)) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else begin
          gap_cnt_d = '0;
          state_d   = SEND;
          sr_load   = 1'b1;
          bit_cnt_d = len_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    dvalid_d = (state_d == SEND);
    sof_d    = sr_load;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  seq_gen_shift #(
    .PAT_W (PAT_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .shift_en (sr_shift),
    .load_val (sr_load_val),
    .msb      (dout)
  );

  assign dvalid    = dvalid_q;
  assign sof       = sof_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Bench for seq_gen_tx: per-cycle stream model with an expected queue, directed
// literal frames, a mid-frame reset and a randomized phase.
module tb_seq_gen_tx;
  import seq_gen_pkg::*;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;
  localparam int GAP_W = 4;
  localparam int W     = 5;  // {dout, dvalid, sof, busy, done}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             start   = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [LEN_W-1:0] len     = '0;
  logic [REP_W-1:0] reps    = '0;
  logic [GAP_W-1:0] gap     = '0;
  logic             dout, dvalid, sof, busy, done;
  state_t           dbg_state;

  seq_gen_tx #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .REP_W (REP_W),
    .GAP_W (GAP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .gap       (gap),
    .dout      (dout),
    .dvalid    (dvalid),
    .sof       (sof),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // scoreboard: one expected output word per cycle of a frame
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_cur = '0;
  bit           chk_en  = 1'b0;

  function automatic void push_frame(input logic [PAT_W-1:0] p, input int l, input int r, input int g);
    int ln;
    int rp;
    ln = (l > PAT_W) ? PAT_W : l;
    rp = (r == 0) ? 1 : r;
    if (ln > 0) begin
      for (int k = 0; k < rp; k++) begin
        for (int i = ln - 1; i >= 0; i--)
          exp_q.push_back({p[i], 1'b1, (i == ln - 1), 1'b1, 1'b0});
        if (k < rp - 1)
          for (int j = 0; j < g; j++) exp_q.push_back(5'b00010);
      end
    end
    exp_q.push_back(5'b00011);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      exp_cur = '0;
    end else begin
      if (exp_q.size() == 0 && exp_cur[1] == 1'b0 && start)
        push_frame(pattern, int'(len), int'(reps), int'(gap));
      exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) check("stream", {dout, dvalid, sof, busy, done}, exp_cur);
  end

  // driver tasks
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && !exp_cur[1]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", busy, 0);
  endtask

  task automatic run_frame(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l,
                           input logic [REP_W-1:0] r, input logic [GAP_W-1:0] g,
                           input int ncyc, input bit disturb,
                           output logic [31:0] vd, output logic [31:0] vv,
                           output logic [31:0] vs, output logic [31:0] vb,
                           output logic [31:0] vn);
    vd = '0; vv = '0; vs = '0; vb = '0; vn = '0;
    @(negedge clk);
    pattern = p; len = l; reps = r; gap = g; start = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      vd = {vd[30:0], dout};
      vv = {vv[30:0], dvalid};
      vs = {vs[30:0], sof};
      vb = {vb[30:0], busy};
      vn = {vn[30:0], done};
      start = 1'b0;
      if (disturb && k == 1) begin
        start   = 1'b1;
        pattern = ~p;
        len     = 4'd8;
        reps    = 4'd3;
      end
    end
    start = 1'b0;
  endtask

  logic [31:0] vd, vv, vs, vb, vn;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs", {dout, dvalid, sof, busy, done}, 0);
    check("reset_state", dbg_state, IDLE);
    rst = 1'b1;
    wait_idle();

    // single frame 0x0B, len 4
    run_frame(8'h0B, 4'd4, 4'd1, 4'd0, 6, 1'b0, vd, vv, vs, vb, vn);
    check("single_dout",   vd, 32'b101100);
    check("single_dvalid", vv, 32'b111100);
    check("single_sof",    vs, 32'b100000);
    check("single_done",   vn, 32'b000010);
    check("single_busy",   vb, 32'b111110);
    wait_idle();

    // same frame with start/pattern/len disturbed mid-SEND
    run_frame(8'h0B, 4'd4, 4'd1, 4'd0, 8, 1'b1, vd, vv, vs, vb, vn);
    check("ignore_dout", vd, 32'b10110000);
    check("ignore_busy", vb, 32'b11111000);
    check("ignore_done", vn, 32'b00001000);
    wait_idle();

    // two repetitions, one idle cycle between
    run_frame(8'h0B, 4'd4, 4'd2, 4'd1, 11, 1'b0, vd, vv, vs, vb, vn);
    check("gap_dout",   vd, 32'b10110101100);
    check("gap_dvalid", vv, 32'b11110111100);
    check("gap_sof",    vs, 32'b10000100000);
    check("gap_done",   vn, 32'b00000000010);
    check("gap_busy",   vb, 32'b11111111110);
    wait_idle();

    // back-to-back repetitions of 3'b101
    run_frame(8'h05, 4'd3, 4'd3, 4'd0, 11, 1'b0, vd, vv, vs, vb, vn);
    check("b2b_dout",   vd, 32'b10110110100);
    check("b2b_dvalid", vv, 32'b11111111100);
    check("b2b_sof",    vs, 32'b10010010000);
    check("b2b_done",   vn, 32'b00000000010);
    wait_idle();

    // len = 0: only the DONE cycle
    run_frame(8'hFF, 4'd0, 4'd2, 4'd0, 3, 1'b0, vd, vv, vs, vb, vn);
    check("len0_dvalid", vv, 32'b000);
    check("len0_done",   vn, 32'b100);
    check("len0_busy",   vb, 32'b100);
    wait_idle();

    // len = 15 clamps to 8
    run_frame(8'hA5, 4'd15, 4'd1, 4'd0, 10, 1'b0, vd, vv, vs, vb, vn);
    check("clamp_dout",   vd, 32'b1010010100);
    check("clamp_dvalid", vv, 32'b1111111100);
    check("clamp_done",   vn, 32'b0000000010);
    wait_idle();

    // reps = 0 behaves as one repetition
    run_frame(8'h0B, 4'd4, 4'd0, 4'd3, 6, 1'b0, vd, vv, vs, vb, vn);
    check("reps0_dout", vd, 32'b101100);
    check("reps0_done", vn, 32'b000010);
    wait_idle();

    // reset in the middle of a frame
    @(negedge clk);
    pattern = 8'hFF; len = 4'd8; reps = 4'd2; gap = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_dvalid", dvalid, 1);
    #1 rst = 1'b0;
    #1;
    check("async_reset_outputs", {dout, dvalid, sof, busy, done}, 0);
    check("async_reset_state", dbg_state, IDLE);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
    end

    // randomized phase, including start held across frame boundaries
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 2) == 0);
      pattern = PAT_W'($urandom);
      len     = LEN_W'($urandom_range(0, 15));
      reps    = REP_W'($urandom_range(0, 3));
      gap     = GAP_W'($urandom_range(0, 3));
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_gen_tx.md
# seq_gen_tx

Serial pattern transmitter: the transmit-side counterpart of the team's serial sequence detectors. On a start request it latches a bit pattern of programmable length and drives it MSB-first onto a one-bit serial line, one bit per clock. It can repeat the pattern a programmable number of times with a programmable idle gap between repetitions. It sits upstream of a detector and drives its `din`, in the design and in loop-back benches.

## Interface
Parameters:
- `PAT_W`, default 8: maximum pattern length in bits.
- `LEN_W`, default `$clog2(PAT_W+1)`: width of `len`.
- `REP_W`, default 4: width of `reps`.
- `GAP_W`, default 4: width of `gap`.

Ports:
- `clk` in, 1: single clock; all state changes on its rising edge.
- `rst` in, 1: reset, asynchronous and active-low.
- `start` in, 1: request a transmission; sampled only while `busy`=0.
- `pattern` in, `PAT_W`: bits to send; only `pattern[len-1:0]` is used.
- `len` in, `LEN_W`: number of pattern bits; values above `PAT_W` are clamped to `PAT_W`.
- `reps` in, `REP_W`: number of pattern repetitions; 0 is treated as 1.
- `gap` in, `GAP_W`: idle cycles between repetitions; 0 means back-to-back.
- `dout` out, 1: serial data.
- `dvalid` out, 1: `dout` carries a pattern bit.
- `sof` out, 1: high with the first bit of each repetition.
- `busy` out, 1: high from accept through the DONE cycle.
- `done` out, 1: one-cycle pulse after the final bit.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- Reset (`rst`=0): state IDLE; `dout`, `dvalid`, `sof`, `busy`, `done` all 0, immediately and asynchronously. Counters and shift register are cleared. Reset mid-transmission aborts with no `done` pulse.
- IDLE, `start`=1 at an edge:
  - Latch `pattern`, clamped `len`, effective `reps`, and `gap`. Later input changes are ignored until the next accept.
  - If `len`=0, go to DONE with no `dvalid`.
  - Otherwise go to SEND and load the shift register.
- SEND:
  - Each edge presents the next bit: `pattern[len-1]` first, `pattern[0]` last.
  - `dvalid`=1. `sof`=1 on the first bit of each repetition.
  - After bit `pattern[0]`: if repetitions remain and `gap`>0, go to GAP. If repetitions remain and `gap`=0, reload and continue in SEND, so the next repetition's first bit follows directly. If this was the last repetition, go to DONE.
- GAP: `dout`=0, `dvalid`=0 for exactly `gap` cycles, then SEND with a reloaded pattern.
- DONE: `done`=1, `busy`=1, `dout`=0, `dvalid`=0 for one cycle, then IDLE.
- `start` while `busy`=1 is ignored; it is not queued.
- Bit counter is `LEN_W` wide, gap counter `GAP_W` wide, repetition counter `REP_W` wide. All count down; none wraps.

## Timing
- All outputs are registered.
- Accept edge E0 (`start`=1, state IDLE): the first bit, `sof`=1 and `busy`=1 are visible in the cycle after E0.
- Repetition r (0-based) starts at edge E0 + r·(len+gap).
- Total `dvalid` cycles = reps·len.
- Total busy cycles = reps·len + (reps−1)·gap + 1 (the DONE cycle).
- `busy` falls at the edge after DONE. `start` asserted in that same cycle is accepted at the next edge, giving a minimum of one IDLE cycle between frames.

## Structure
- Shared package `seq_gen_pkg` holds:
  - `state_t` enum (IDLE, SEND, GAP, DONE) with its 2-bit encodings.
  - Default width constants for `PAT_W`, `REP_W`, `GAP_W`.
- One sub-module is natural: `seq_gen_shift`, a loadable `PAT_W`-bit left shift register with load, shift-enable and serial MSB output. The FSM and counters stay in `seq_gen_tx`.

## Test plan
- Reset: assert `rst`=0 mid-SEND → all outputs 0 in the same cycle; after release, state is IDLE and there is no `done` pulse.
- Single frame: `pattern`=8'h0B, `len`=4, `reps`=1, `gap`=0, start at E0 → `dout` 1,0,1,1 in the cycles after E0..E0+3 with `dvalid`=1; `sof` only on the first bit; `done` after E0+4; `busy`=0 after E0+5.
- Repeat with gap: same pattern, `reps`=2, `gap`=1 → bits 1,0,1,1, one idle cycle, then 1,0,1,1; `sof` twice; `done` after E0+9.
- Back-to-back repeat: `reps`=3, `gap`=0, `len`=3, `pattern`=3'b101 → 101101101 continuous, `dvalid` high for 9 cycles, `sof` every 3rd cycle.
- Edge inputs:
  - `len`=0 → DONE pulse after one cycle with no `dvalid`.
  - `len`=15 with `PAT_W`=8 → 8 bits sent.
  - `reps`=0 → one repetition.
- Ignored inputs: during SEND, pulse `start` and change `pattern`/`len` → output stream unchanged, no second frame.
